// File: rtl/fpdiv_pkg.sv
// Shared state and select encodings for the Goldschmidt divider sequencer.
package fpdiv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_INIT_N,
    ST_INIT_D,
    ST_ITER_N,
    ST_ITER_D,
    ST_REM,
    ST_RESULT,
    ST_DONE
  } fpdiv_state_t;

  localparam logic [1:0] SEL3_IA  = 2'b00;
  localparam logic [1:0] SEL3_C   = 2'b01;
  localparam logic [1:0] SEL3_REM = 2'b10;

  localparam logic [1:0] SEL4_NIA = 2'b00;
  localparam logic [1:0] SEL4_DIA = 2'b01;
  localparam logic [1:0] SEL4_NC  = 2'b10;
  localparam logic [1:0] SEL4_DC  = 2'b11;

  function automatic logic [1:0] sel3_of(fpdiv_state_t s);
    case (s)
      ST_INIT_N, ST_INIT_D: return SEL3_IA;
      ST_ITER_N, ST_ITER_D: return SEL3_C;
      ST_REM:               return SEL3_REM;
      default:              return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] sel4_of(fpdiv_state_t s);
    case (s)
      ST_INIT_N: return SEL4_NIA;
      ST_INIT_D: return SEL4_DIA;
      ST_ITER_N: return SEL4_NC;
      ST_ITER_D: return SEL4_DC;
      ST_REM:    return SEL4_NC;
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic is_step(fpdiv_state_t s);
    return (s == ST_INIT_N) || (s == ST_INIT_D) || (s == ST_ITER_N) ||
           (s == ST_ITER_D) || (s == ST_REM);
  endfunction

endpackage

// File: rtl/fpdiv_step_timer.sv
// Per-step down-counter: reloads MUL_LAT-1 on step entry, flags the final cycle.
module fpdiv_step_timer #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  output logic last,
  output logic last_nxt
);

  localparam int unsigned CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] RELOAD = CW'(MUL_LAT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = RELOAD;
    else if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last     = (cnt_q == '0);
  // Lets the owner register a strobe that lands on the step's final cycle.
  assign last_nxt = (cnt_d == '0);

endmodule

// File: rtl/fpdiv_seq.sv
// Control sequencer for the Goldschmidt divider: one start/ready handshake
// drives capture, IA multiply, refinement pairs, remainder and result strobes.
module fpdiv_seq
  import fpdiv_pkg::*;
#(
  parameter int unsigned ITERS   = 6,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       flush,
  input  logic       rm_in,
  output logic       ready,
  output logic       en_op,
  output logic [1:0] sel_mux3,
  output logic [1:0] sel_mux4,
  output logic       en_a,
  output logic       en_b,
  output logic       en_rem,
  output logic       en_res,
  output logic       rm,
  output logic [3:0] iter,
  output logic       done
);

  if (ITERS < 2 || ITERS > 15) begin : g_bad_iters
    $fatal(1, "fpdiv_seq: ITERS must be in 2..15");
  end
  if (MUL_LAT < 1 || MUL_LAT > 4) begin : g_bad_lat
    $fatal(1, "fpdiv_seq: MUL_LAT must be in 1..4");
  end

  localparam logic [3:0] ITERS_W = 4'(ITERS);

  fpdiv_state_t state_q, state_d;
  logic [3:0]   iter_q, iter_d;
  logic         rm_q, rm_d;
  logic         step_load;
  logic         last, last_nxt;

  logic       ready_d, en_op_d, en_a_d, en_b_d, en_rem_d, en_res_d, done_d;
  logic [1:0] sel3_d, sel4_d;

  fpdiv_step_timer #(.MUL_LAT(MUL_LAT)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (step_load),
    .last     (last),
    .last_nxt (last_nxt)
  );

  always_comb begin
    state_d = state_q;
    rm_d    = rm_q;
    iter_d  = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d = ST_LOAD;
          rm_d    = rm_in;
        end
      end
      ST_LOAD:   state_d = ST_INIT_N;
      ST_INIT_N: if (last) state_d = ST_INIT_D;
      ST_INIT_D: if (last) state_d = ST_ITER_N;
      ST_ITER_N: if (last) state_d = ST_ITER_D;
      ST_ITER_D: if (last) state_d = (iter_q == ITERS_W) ? ST_REM : ST_ITER_N;
      ST_REM:    if (last) state_d = ST_RESULT;
      ST_RESULT: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (flush && state_q != ST_IDLE)
      state_d = ST_IDLE;

    if (state_d == ST_IDLE)
      iter_d = '0;
    else if (state_d == ST_INIT_N && state_q != ST_INIT_N)
      iter_d = 4'd1;
    else if (state_d == ST_ITER_N && state_q != ST_ITER_N)
      iter_d = iter_q + 4'd1;
  end

  // Every step boundary is a state change, so a change reloads the timer.
  assign step_load = (state_d != state_q);

  // Outputs are decoded from the next state so they leave the flops directly.
  always_comb begin
    ready_d  = (state_d == ST_IDLE);
    en_op_d  = (state_d == ST_LOAD);
    sel3_d   = sel3_of(state_d);
    sel4_d   = sel4_of(state_d);
    en_a_d   = ((state_d == ST_INIT_N) || (state_d == ST_ITER_N)) && last_nxt;
    en_b_d   = ((state_d == ST_INIT_D) || (state_d == ST_ITER_D)) && last_nxt;
    en_rem_d = (state_d == ST_REM) && last_nxt && is_step(state_d);
    en_res_d = (state_d == ST_RESULT);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      iter_q   <= '0;
      rm_q     <= 1'b0;
      ready    <= 1'b1;
      en_op    <= 1'b0;
      sel_mux3 <= 2'b00;
      sel_mux4 <= 2'b00;
      en_a     <= 1'b0;
      en_b     <= 1'b0;
      en_rem   <= 1'b0;
      en_res   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      rm_q     <= rm_d;
      ready    <= ready_d;
      en_op    <= en_op_d;
      sel_mux3 <= sel3_d;
      sel_mux4 <= sel4_d;
      en_a     <= en_a_d;
      en_b     <= en_b_d;
      en_rem   <= en_rem_d;
      en_res   <= en_res_d;
      done     <= done_d;
    end
  end

  assign rm   = rm_q;
  assign iter = iter_q;

endmodule

// File: doc/fpdiv_seq.md
# fpdiv_seq

Parametrised control sequencer for the Goldschmidt floating-point divider datapath (`fpdiv`). It replaces hand-driven bench control with an on-chip FSM. On a `start`/`ready` handshake it issues the complete step sequence for one division:

- operand capture;
- initial-approximation multiply (N·IA, then D·IA);
- `ITERS`−1 refinement pairs;
- remainder step;
- result capture.

Iteration count and multiplier latency are configurable, and an in-flight division can be flushed.

## Interface
- `ITERS`, 6, total Goldschmidt iterations including the IA step; legal range 2..15
- `MUL_LAT`, 1, multiplier latency in cycles; each datapath step is held this long; legal range 1..4
- `clk` in 1: rising-edge clock
- `reset_n` in 1: reset, asynchronous, active-low
- `start` in 1: request; accepted only when `ready`=1
- `flush` in 1: synchronous abort to IDLE; priority over all but reset
- `rm_in` in 1: rounding mode, sampled on accept
- `ready` out 1: FSM in IDLE
- `en_op` out 1: datapath latches N, D
- `sel_mux3` out 2: 00 = IA, 01 = C register, 10 = remainder path
- `sel_mux4` out 2: 00 = N·IA, 01 = D·IA, 10 = N·C, 11 = D·C
- `en_a` / `en_b` / `en_rem` / `en_res` out 1 each: register load strobes
- `rm` out 1: rounding mode held for the whole operation
- `iter` out 4: current iteration number (1..`ITERS`), 0 in IDLE
- `done` out 1: one-cycle completion pulse

## Operation
- **States:** IDLE → LOAD → INIT_N → INIT_D → ITER_N ⇄ ITER_D → REM → RESULT → DONE → IDLE.
- **IDLE**
  - `ready`=1.
  - `start`=1 at a clock edge: latch `rm_in` into `rm`, then go to LOAD.
- **LOAD** (1 cycle): `en_op`=1.
- **INIT_N**: `sel_mux3`=00, `sel_mux4`=00; `en_a` strobed. `iter`=1.
- **INIT_D**: `sel_mux3`=00, `sel_mux4`=01; `en_b` strobed.
- **ITER_N**: `sel_mux3`=01, `sel_mux4`=10; `en_a` strobed. `iter` incremented on entry.
- **ITER_D**: `sel_mux3`=01, `sel_mux4`=11; `en_b` strobed.
  - Exits to REM when `iter`==`ITERS`, else back to ITER_N.
- **REM**: `sel_mux3`=10, `sel_mux4`=10; `en_rem` strobed.
- **RESULT** (1 cycle): `en_res`=1.
- **DONE** (1 cycle): `done`=1; next state IDLE.
- **Step hold:** each of INIT_N, INIT_D, ITER_N, ITER_D and REM lasts exactly `MUL_LAT` cycles.
  - Selects are stable for the whole step.
  - The step's enable is asserted only in its final cycle.
  - A step counter of width clog2(`MUL_LAT`+1) runs per step.
- **Strobes:** at most one of `en_op`, `en_a`, `en_b`, `en_rem`, `en_res` is high in any cycle.
- **Outputs outside active states:** selects are 00 in IDLE, LOAD, RESULT and DONE.
- **`start` while busy:** ignored, not queued.
- **Ignored `start` cycles:** `start` in the DONE cycle is ignored (`ready`=0). The earliest back-to-back accept is the cycle after `done`.
- **`flush`** in any non-IDLE state:
  - next edge goes to IDLE;
  - no further strobes;
  - no `done`.
- **`flush` with `start` in IDLE:** `flush` wins; `start` is not accepted.

## Timing
- **Reset values:** `ready`=1, `rm`=0, `iter`=0; every other output 0.
- **Reset is asynchronous:** it takes effect mid-operation without waiting for a clock edge, and no pulse follows release.
- **Cycle numbering:** the accept edge is cycle 0.
  - LOAD occupies cycle 1.
  - The datapath sequence occupies (2·`ITERS`+1)·`MUL_LAT` cycles.
  - RESULT occupies the following cycle.
  - `done` is high in cycle 2+(2·`ITERS`+1)·`MUL_LAT`+1.
- **Defaults** (`ITERS`=6, `MUL_LAT`=1): `done` in cycle 16; throughput one division per 17 cycles.
- **`MUL_LAT`=3, `ITERS`=6:** `done` in cycle 42.
- **Output registration:** all outputs are registered; no combinational path from `start`/`flush` to any output.

## Structure
- **Package `fpdiv_pkg`:**
  - state enum `fpdiv_state_t`;
  - `localparam`s for the `sel_mux3`/`sel_mux4` encodings (`SEL3_IA`, `SEL3_C`, `SEL3_REM`, `SEL4_NIA`, `SEL4_DIA`, `SEL4_NC`, `SEL4_DC`).
- **Sub-module `fpdiv_step_timer`:**
  - loads `MUL_LAT`−1 on step entry and counts down;
  - asserts `last` at 0.
  - The FSM uses `last` to gate the enable and advance state.
- **Elaboration checks:** out-of-range `ITERS`/`MUL_LAT` raise an elaboration-time assertion.

## Test plan
- **Defaults, single op.** `start` at cycle 0, `rm_in`=1.
  - Required: `en_op` at 1; `en_a` at 2; `en_b` at 3; alternating `en_a`/`en_b` in 4..13 with `sel_mux4`=10/11; `en_rem` at 14; `en_res` at 15; `done` at 16; `rm`=1 throughout.
- **`MUL_LAT`=3, `ITERS`=4.** Single op.
  - Selects held 3 cycles each; each strobe only in the 3rd cycle.
  - `done` in cycle 30; `iter` sequence 1,2,3,4.
- **Busy and back-to-back.** `start` held high continuously.
  - Accepts at cycles 0 and 17 only; exactly one `done` per accept.
- **`flush` mid-iteration.** `flush` in cycle 8.
  - Cycle 9 is IDLE with `ready`=1, all strobes 0, no `done`.
  - A new `start` in cycle 10 completes normally in cycle 26.
- **Async reset.** `reset_n` low at cycle 6.5.
  - Outputs return to reset values before the next edge.
  - After release, no stray strobes and `ready`=1.
- **Sequence properties on random `start`/`flush` traffic.**
  - Strobes are one-hot-or-zero every cycle.
  - Selects never change inside a step.
